if_jump_redirect: RTL and testbench
===================================

// Module: if_jump_redirect
// PURPOSE
//  Fetch-side consumer of the ID-stage jump decode: holds the PC, drives instruction-memory
//  address, loads the IF/ID pipeline register and redirects the PC on a decoded J.
//  Run/step/halt controls come from the UART debug controller; stall comes from hazard unit.
//  Sits between instruction memory (async read) and the instruction_decode stage.
// PARAMETERS
//  PC_WIDTH     32            width of PC, imem_addr, pc_plus4 paths
//  RESET_PC     32'h00000000  PC value loaded on reset
//  INSTR_WIDTH  32            instruction word width
// PORTS
//  clk              in   1            rising-edge clock
//  reset            in   1            synchronous, active-high
//  run              in   1            pulse: start free-running fetch
//  step             in   1            pulse: advance exactly one cycle
//  halt_req         in   1            pulse: stop after the current advance
//  stall            in   1            hazard stall: hold PC and IF/ID
//  jump_sel         in   1            from ID: instruction in IF/ID is J
//  jump_index       in   26           instr_index field of the IF/ID instruction
//  imem_data        in   INSTR_WIDTH  instruction at imem_addr (combinational read)
//  imem_addr        out  PC_WIDTH     = pc register (combinational)
//  if_id_instr      out  INSTR_WIDTH  IF/ID instruction register
//  if_id_pc_plus4   out  PC_WIDTH     IF/ID PC+4 register
//  if_id_valid      out  1            IF/ID holds a real instruction (0 = bubble)
//  running          out  1            1 in RUN state
//  cycle_count      out  32           number of advances since reset
// BEHAVIOUR
//  Reset (sync, highest priority): pc=RESET_PC, if_id_instr=0, if_id_pc_plus4=0,
//   if_id_valid=0, state=IDLE, running=0, cycle_count=0. Mid-operation reset discards all.
//  FSM: IDLE, RUN, STEP.
//   IDLE: no advance. run -> RUN; else step -> STEP. run and step together: run wins.
//   STEP: one advance (if not stalled), then -> IDLE. If stalled, stay STEP until advance.
//   RUN : advance every non-stalled cycle; halt_req -> IDLE after this cycle's advance.
//   running=1 only in RUN (registered with state).
//  Advance (one cycle, state RUN/STEP and stall=0):
//   jump_taken = jump_sel & if_id_valid (jump_sel on a bubble is ignored).
//   target = {if_id_pc_plus4[PC_WIDTH-1:28], jump_index, 2'b00}.
//   pc <= jump_taken ? target : pc+4 (mod 2^PC_WIDTH, wraps to 0).
//   IF/ID <= {imem_data, pc+4, valid=1}, except squash rule below.
//   cycle_count <= cycle_count+1 (wraps at 2^32).
//  Stall=1: pc, IF/ID, cycle_count hold; jump_sel re-evaluated when stall drops.
//  Priority per edge: reset > stall > jump_taken > sequential.
//  Latency: jump in IF/ID at edge N -> imem_addr=target after edge N; target instr in
//   IF/ID after edge N+1.
// CONFIGURATION
//  IF_DELAY_SLOT_EN defined: instruction fetched alongside a taken jump (delay slot)
//   enters IF/ID normally with valid=1.
//  Not defined: on jump_taken, IF/ID <= {32'h0 (NOP), pc+4, valid=0} (one-bubble squash).
// TESTING
//  Reset, then run; imem returns 32'h20010001 everywhere -> imem_addr 0,4,8,12 on
//   successive edges, if_id_valid=1 from first advance, cycle_count=3 after 3 edges.
//  J at addr 8 (32'h08000010) -> after it reaches IF/ID imem_addr=32'h40; without macro
//   IF/ID holds 0/valid=0 one cycle; with IF_DELAY_SLOT_EN instr at 12 is valid.
//  stall=1 for 3 cycles during RUN with J in IF/ID -> pc, IF/ID, cycle_count frozen;
//   redirect to target occurs on first edge after stall=0.
//  From IDLE, step pulse at pc=4 -> exactly one advance (pc=8, cycle_count+1), back to IDLE;
//   run+step same cycle -> RUN, running=1.
//  RUN with pc=32'hFFFFFFFC -> next pc=0; halt_req with jump_taken same cycle -> pc=target,
//   state IDLE, running=0.
//  reset asserted while RUN at pc=32'h100 -> next edge all outputs at reset values.

Source files
------------

// File: rtl/if_jump_redirect.sv
// Fetch stage: PC register, IF/ID pipeline register and J redirect under run/step/halt control.
// Optional IF_DELAY_SLOT_EN: the instruction fetched alongside a taken jump enters IF/ID as valid.
module if_jump_redirect #(
  parameter int unsigned           PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
  parameter int unsigned           INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   step,
  input  logic                   halt_req,
  input  logic                   stall,
  input  logic                   jump_sel,
  input  logic [25:0]            jump_index,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus4,
  output logic                   if_id_valid,
  output logic                   running,
  output logic [31:0]            cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP
  } state_e;

  state_e                 state_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0]    pc4_q;
  logic                   valid_q;
  logic                   running_q;
  logic [31:0]            cnt_q;

  logic                   advance_d;
  logic                   jump_taken_d;
  logic [PC_WIDTH-1:0]    pc_plus4_d;
  logic [PC_WIDTH-1:0]    target_d;

  always_comb begin
    advance_d    = (state_q != S_IDLE) && !stall;
    // A jump decode on a bubble must not redirect.
    jump_taken_d = jump_sel && valid_q;
    pc_plus4_d   = pc_q + PC_WIDTH'(4);
    target_d     = {pc4_q[PC_WIDTH-1:28], jump_index, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      pc4_q     <= '0;
      valid_q   <= 1'b0;
      running_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end else if (step) begin
            state_q   <= S_STEP;
            running_q <= 1'b0;
          end else begin
            running_q <= 1'b0;
          end
        end
        S_STEP: begin
          running_q <= 1'b0;
          if (advance_d) state_q <= S_IDLE;
        end
        S_RUN: begin
          if (halt_req) begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
          end else begin
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
        end
      endcase

      if (advance_d) begin
        cnt_q <= cnt_q + 32'd1;
        pc4_q <= pc_plus4_d;
        if (jump_taken_d) begin
          pc_q <= target_d;
`ifdef IF_DELAY_SLOT_EN
          instr_q <= imem_data;
          valid_q <= 1'b1;
`else
          instr_q <= '0;
          valid_q <= 1'b0;
`endif
        end else begin
          pc_q    <= pc_plus4_d;
          instr_q <= imem_data;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;
  assign running        = running_q;
  assign cycle_count    = cnt_q;

endmodule

// File: tb/tb_if_jump_redirect.sv
// Directed bench for if_jump_redirect: per-cycle reference model plus hand-computed spot checks.
module tb_if_jump_redirect;

  logic        clk = 1'b0;
  logic        reset, run, step, halt_req, stall;
  logic        jsel_force;
  logic [25:0] f_idx;
  logic        jump_sel;
  logic [25:0] jump_index;
  logic [31:0] imem_data, imem_addr, if_id_instr, if_id_pc_plus4, cycle_count;
  logic        if_id_valid, running;

  logic [31:0] w_data, w_addr, w_instr, w_pc4, w_cnt;
  logic        w_valid, w_running;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0008: return 32'h0800_0010;
      32'h0000_0040: return 32'h2002_0002;
      default:       return 32'h2001_0001;
    endcase
  endfunction

  // ID-stage decode stub, with an override to present jump_sel regardless of IF/ID contents.
  assign imem_data  = imem_rd(imem_addr);
  assign jump_sel   = jsel_force | (if_id_instr[31:26] == 6'b000010);
  assign jump_index = jsel_force ? f_idx : if_id_instr[25:0];
  assign w_data     = imem_rd(w_addr);

  if_jump_redirect #(.PC_WIDTH(32), .RESET_PC(32'h0), .INSTR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req), .stall(stall),
    .jump_sel(jump_sel), .jump_index(jump_index), .imem_data(imem_data),
    .imem_addr(imem_addr), .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .running(running), .cycle_count(cycle_count)
  );

  if_jump_redirect #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .INSTR_WIDTH(32)) u_wrap (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req), .stall(stall),
    .jump_sel(1'b0), .jump_index(26'd0), .imem_data(w_data),
    .imem_addr(w_addr), .if_id_instr(w_instr), .if_id_pc_plus4(w_pc4),
    .if_id_valid(w_valid), .running(w_running), .cycle_count(w_cnt)
  );

  // Reference model: mode 0=idle, 1=run, 2=step.
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    end else begin
      bit          adv, jt;
      logic [31:0] seq, tgt, fetched;
      logic [25:0] idx;
      adv     = (m_mode != 0) && !stall;
      jt      = (jsel_force || m_instr[31:26] == 6'd2) && m_valid;
      idx     = jsel_force ? f_idx : m_instr[25:0];
      seq     = m_pc + 32'd4;
      tgt     = {m_pc4[31:28], idx, 2'b00};
      fetched = imem_rd(m_pc);
      case (m_mode)
        0: m_mode = run ? 1 : (step ? 2 : 0);
        1: m_mode = halt_req ? 0 : 1;
        default: m_mode = adv ? 0 : 2;
      endcase
      if (adv) begin
        m_cnt = m_cnt + 1;
        m_pc4 = seq;
        m_pc  = jt ? tgt : seq;
`ifdef IF_DELAY_SLOT_EN
        m_instr = fetched; m_valid = 1'b1;
`else
        m_instr = jt ? 32'h0 : fetched; m_valid = !jt;
`endif
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_addr",    imem_addr,             m_pc);
      check("mdl_instr",   if_id_instr,           m_instr);
      check("mdl_pc4",     if_id_pc_plus4,        m_pc4);
      check("mdl_valid",   {31'd0, if_id_valid},  {31'd0, m_valid});
      check("mdl_running", {31'd0, running},      {31'd0, m_mode == 1});
      check("mdl_count",   cycle_count,           m_cnt);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0; stall = 1'b0;
    jsel_force = 1'b0; f_idx = '0;
    tick(2);
    chk_en = 1'b1;
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_count", cycle_count, 32'd0);
    check("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);

    // Free-running fetch with a J at address 8.
    reset = 1'b0; run = 1'b1; tick();
    run = 1'b0; tick();
    check("first_adv_addr",  imem_addr, 32'h4);
    check("first_adv_valid", {31'd0, if_id_valid}, 32'd1);
    tick(2);
    check("three_addr",  imem_addr, 32'hC);
    check("three_count", cycle_count, 32'd3);
    check("j_in_ifid",   if_id_instr, 32'h0800_0010);
    stall = 1'b1; tick(3);
    check("stall_addr",  imem_addr, 32'hC);
    check("stall_count", cycle_count, 32'd3);
    check("stall_instr", if_id_instr, 32'h0800_0010);
    stall = 1'b0; tick();
    check("redir_addr", imem_addr, 32'h40);
`ifdef IF_DELAY_SLOT_EN
    check("slot_instr", if_id_instr, 32'h2001_0001);
    check("slot_valid", {31'd0, if_id_valid}, 32'd1);
`else
    check("squash_instr", if_id_instr, 32'h0);
    check("squash_valid", {31'd0, if_id_valid}, 32'd0);
`endif
    tick();
    check("target_instr", if_id_instr, 32'h2002_0002);
    check("target_pc4",   if_id_pc_plus4, 32'h44);
    halt_req = 1'b1; tick();
    halt_req = 1'b0; tick();
    check("halt_addr",    imem_addr, 32'h48);
    check("halt_count",   cycle_count, 32'd6);
    check("halt_running", {31'd0, running}, 32'd0);
    step = 1'b1; tick();
    step = 1'b0; tick(2);
    check("step_addr",  imem_addr, 32'h4C);
    check("step_count", cycle_count, 32'd7);

    // Forced jump_sel on a bubble is ignored; honoured once IF/ID is valid.
    reset = 1'b1; tick();
    reset = 1'b0; run = 1'b1; jsel_force = 1'b1; f_idx = 26'h3FF; tick();
    run = 1'b0; tick();
    check("bubble_jump_ignored", imem_addr, 32'h4);
    tick();
    check("forced_jump_addr", imem_addr, 32'hFFC);
    jsel_force = 1'b0; halt_req = 1'b1; tick();
    halt_req = 1'b0; run = 1'b1; step = 1'b1; tick();
    check("run_wins_running", {31'd0, running}, 32'd1);
    run = 1'b0; step = 1'b0; tick();
    check("run_adv_addr", imem_addr, 32'h1004);
    jsel_force = 1'b1; f_idx = 26'h20; halt_req = 1'b1; tick();
    check("halt_jump_addr",    imem_addr, 32'h80);
    check("halt_jump_running", {31'd0, running}, 32'd0);
    jsel_force = 1'b0; halt_req = 1'b0; run = 1'b1; tick();
    run = 1'b0; tick();
    jsel_force = 1'b1; f_idx = 26'h40; tick();
    jsel_force = 1'b0;
    check("pre_reset_addr", imem_addr, 32'h100);
    reset = 1'b1; tick();
    check("midrst_addr",    imem_addr, 32'h0);
    check("midrst_instr",   if_id_instr, 32'h0);
    check("midrst_pc4",     if_id_pc_plus4, 32'h0);
    check("midrst_valid",   {31'd0, if_id_valid}, 32'd0);
    check("midrst_running", {31'd0, running}, 32'd0);
    check("midrst_count",   cycle_count, 32'd0);

    // PC wrap on the instance reset near the top of the address space.
    reset = 1'b0; run = 1'b1; tick();
    run = 1'b0; tick();
    check("wrap_fffc", w_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_zero", w_addr, 32'h0);
    check("wrap_pc4",  w_pc4, 32'h0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
